// File: rtl/bp_cce_pending_wr_queue.sv
// Pending-bit write arbiter: microcode writes pass straight through with priority,
// memory-response decrements are queued and drained on idle cycles with starvation protection.
module bp_cce_pending_wr_queue #(
  parameter int num_way_groups_p = 8,
  parameter int els_p            = 4,
  parameter int starve_limit_p   = 8,
  localparam int lg_num_way_groups_lp = (num_way_groups_p <= 1) ? 1 : $clog2(num_way_groups_p),
  localparam int ptr_w_lp             = (els_p <= 1) ? 1 : $clog2(els_p),
  localparam int cnt_w_lp             = $clog2(els_p + 1),
  localparam int starve_w_lp          = $clog2(starve_limit_p + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            inst_w_v_i,
  input  logic [lg_num_way_groups_lp-1:0] inst_way_group_i,
  input  logic                            inst_pending_i,
  input  logic                            mem_w_v_i,
  input  logic [lg_num_way_groups_lp-1:0] mem_way_group_i,
  output logic                            mem_w_ready_o,
  output logic                            w_v_o,
  output logic [lg_num_way_groups_lp-1:0] w_way_group_o,
  output logic                            pending_o,
  output logic                            stall_o,
  output logic                            empty_o
);

  logic [lg_num_way_groups_lp-1:0] mem_r [els_p];
  logic [ptr_w_lp-1:0]             rptr_r, wptr_r;
  logic [cnt_w_lp-1:0]             count_r;
  logic [starve_w_lp-1:0]          starve_cnt_r;

  logic enq, deq, fifo_nonempty;

  assign fifo_nonempty = (count_r != '0);
  assign mem_w_ready_o = (count_r != cnt_w_lp'(els_p));
  assign empty_o       = ~fifo_nonempty;
  assign stall_o       = (starve_cnt_r == starve_w_lp'(starve_limit_p));

  assign enq = mem_w_v_i & mem_w_ready_o;
  assign deq = ~inst_w_v_i & fifo_nonempty;

  // Write port mux; reset suppresses any write, including microcode ones.
  always_comb begin
    w_v_o         = 1'b0;
    w_way_group_o = '0;
    pending_o     = 1'b0;
    if (!reset_i) begin
      if (inst_w_v_i) begin
        w_v_o         = 1'b1;
        w_way_group_o = inst_way_group_i;
        pending_o     = inst_pending_i;
      end else if (fifo_nonempty) begin
        w_v_o         = 1'b1;
        w_way_group_o = mem_r[rptr_r];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq)
      mem_r[wptr_r] <= mem_way_group_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq)
        wptr_r <= (wptr_r == ptr_w_lp'(els_p - 1)) ? '0 : wptr_r + 1'b1;
      if (deq)
        rptr_r <= (rptr_r == ptr_w_lp'(els_p - 1)) ? '0 : rptr_r + 1'b1;
      if (enq && !deq)
        count_r <= count_r + 1'b1;
      else if (deq && !enq)
        count_r <= count_r - 1'b1;
    end
  end

  // Counts cycles the queue head is blocked by microcode traffic.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      starve_cnt_r <= '0;
    else if (deq || !fifo_nonempty)
      starve_cnt_r <= '0;
    else if (inst_w_v_i && !stall_o)
      starve_cnt_r <= starve_cnt_r + 1'b1;
  end

endmodule

// File: tb/tb_bp_cce_pending_wr_queue.sv
// Directed and random checks of the pending write queue against a queue-based reference model.
module tb_bp_cce_pending_wr_queue;

  localparam int NWG = 8;
  localparam int ELS = 4;
  localparam int LIM = 8;

  logic       clk = 1'b0;
  logic       reset_i = 1'b0;
  logic       inst_w_v_i = 1'b0;
  logic [2:0] inst_way_group_i = '0;
  logic       inst_pending_i = 1'b0;
  logic       mem_w_v_i = 1'b0;
  logic [2:0] mem_way_group_i = '0;
  logic       mem_w_ready_o, w_v_o, pending_o, stall_o, empty_o;
  logic [2:0] w_way_group_o;

  int total = 0;
  int bad = 0;

  int  model_q[$];
  int  model_starve = 0;
  bit  model_known = 0;

  bp_cce_pending_wr_queue #(
    .num_way_groups_p(NWG),
    .els_p(ELS),
    .starve_limit_p(LIM)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .inst_w_v_i(inst_w_v_i),
    .inst_way_group_i(inst_way_group_i),
    .inst_pending_i(inst_pending_i),
    .mem_w_v_i(mem_w_v_i),
    .mem_way_group_i(mem_way_group_i),
    .mem_w_ready_o(mem_w_ready_o),
    .w_v_o(w_v_o),
    .w_way_group_o(w_way_group_o),
    .pending_o(pending_o),
    .stall_o(stall_o),
    .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic applyStimulus(input bit rst, input bit iv, input int iwg, input bit ip,
                               input bit mv, input int mwg);
    bit exp_wv, exp_pd, deq, enq;
    int exp_wg;
    @(negedge clk);
    reset_i          = rst;
    inst_w_v_i       = iv;
    inst_way_group_i = 3'(iwg);
    inst_pending_i   = ip;
    mem_w_v_i        = mv;
    mem_way_group_i  = 3'(mwg);
    #1;
    exp_wv = 0; exp_wg = 0; exp_pd = 0;
    if (!rst) begin
      if (iv) begin
        exp_wv = 1; exp_wg = iwg; exp_pd = ip;
      end else if (model_q.size() > 0) begin
        exp_wv = 1; exp_wg = model_q[0];
      end
    end
    checkOutput("w_v", 32'(w_v_o), 32'(exp_wv));
    checkOutput("w_way_group", 32'(w_way_group_o), 32'(exp_wg));
    checkOutput("pending", 32'(pending_o), 32'(exp_pd));
    if (model_known) begin
      checkOutput("mem_w_ready", 32'(mem_w_ready_o), 32'(model_q.size() != ELS));
      checkOutput("empty", 32'(empty_o), 32'(model_q.size() == 0));
      checkOutput("stall", 32'(stall_o), 32'(model_starve == LIM));
    end
    if (rst) begin
      model_q.delete();
      model_starve = 0;
      model_known  = 1;
    end else begin
      deq = !iv && model_q.size() > 0;
      enq = mv && model_q.size() != ELS;
      if (deq || model_q.size() == 0) model_starve = 0;
      else if (iv && model_starve < LIM) model_starve++;
      if (deq) void'(model_q.pop_front());
      if (enq) model_q.push_back(mwg);
    end
  endtask

  initial begin
    // Reset with both sources active.
    applyStimulus(1, 1, 2, 1, 1, 7);
    applyStimulus(1, 1, 2, 1, 1, 7);
    applyStimulus(0, 1, 2, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Priority: queued 3 waits behind a microcode increment to 5.
    applyStimulus(0, 0, 0, 0, 1, 3);
    applyStimulus(0, 1, 5, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Fill while busy, then drain with wrap and late enqueues.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 1, 1, i);
    applyStimulus(0, 1, 1, 0, 1, 6);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 4);
    applyStimulus(0, 0, 0, 0, 1, 5);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    // Simultaneous enqueue and dequeue at count 2.
    applyStimulus(0, 1, 0, 1, 1, 1);
    applyStimulus(0, 1, 0, 1, 1, 2);
    applyStimulus(0, 0, 0, 0, 1, 3);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    // Starvation: one entry blocked for the full limit.
    applyStimulus(0, 0, 0, 0, 1, 7);
    for (int i = 0; i < LIM; i++) applyStimulus(0, 1, 4, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Reset mid-drain discards queued entries.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 6, 0, 1, i + 2);
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);

    // Random traffic from a compliant engine.
    for (int i = 0; i < 400; i++) begin
      bit rr, iv, mv;
      rr = ($urandom_range(0, 99) < 2);
      iv = ($urandom_range(0, 99) < 60) && (model_starve != LIM);
      mv = ($urandom_range(0, 99) < 50);
      applyStimulus(rr, iv, int'($urandom_range(0, NWG - 1)), 1'($urandom_range(0, 1)),
                    mv, int'($urandom_range(0, NWG - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_cce_pending_wr_queue.md
# bp_cce_pending_wr_queue

Write-side front end for the CCE pending-bit counters. It merges two sources of pending-bit updates onto the single write port of the pending-bit store: the microcode engine, which increments and decrements at instruction rate, and the memory-response path, which decrements when a transaction completes. Microcode writes are issued combinationally with fixed priority. Memory-response decrements are buffered in a small FIFO and drained on idle cycles, with starvation protection.

## Interface
- num_way_groups_p, "inv": number of way groups; lg_num_way_groups_lp = `BSG_SAFE_CLOG2(num_way_groups_p)`.
- els_p, 4: memory-decrement FIFO depth; must be ≥2.
- starve_limit_p, 8: consecutive blocked cycles before stall_o asserts; must be ≥1.

- clk_i  input  1  clock; all state updates on posedge.
- reset_i  input  1  synchronous, active-high reset.
- inst_w_v_i  input  1  microcode pending write valid; no backpressure.
- inst_way_group_i  input  lg_num_way_groups_lp  microcode target way group.
- inst_pending_i  input  1  1 = increment, 0 = decrement.
- mem_w_v_i  input  1  memory-response decrement valid.
- mem_way_group_i  input  lg_num_way_groups_lp  decrement target way group.
- mem_w_ready_o  output  1  FIFO can accept; handshake is mem_w_v_i & mem_w_ready_o.
- w_v_o  output  1  write valid to the pending-bit store.
- w_way_group_o  output  lg_num_way_groups_lp  write way group.
- pending_o  output  1  write direction (1 = increment).
- stall_o  output  1  request to the microcode engine to withhold inst_w_v_i for one cycle.
- empty_o  output  1  FIFO empty.

## Operation
- FIFO: circular buffer of els_p way-group entries, with read pointer, write pointer, and count register of width `BSG_SAFE_CLOG2(els_p+1)`. Pointers wrap from els_p-1 to 0.
- mem_w_ready_o = (count != els_p). Enqueue when mem_w_v_i & mem_w_ready_o.
- Output mux:
  - When inst_w_v_i=1: w_v_o=1, w_way_group_o=inst_way_group_i, pending_o=inst_pending_i. The FIFO is not dequeued.
  - Otherwise, when count != 0: w_v_o=1, w_way_group_o=FIFO head, pending_o=0, and the head is dequeued.
  - Otherwise: w_v_o=0, pending_o=0, and w_way_group_o=0.
- No bypass: a decrement enqueued in cycle t is issued no earlier than t+1.
- Simultaneous enqueue and dequeue: count is unchanged, and both pointers advance.
- Enqueue while full is impossible because ready is 0. Dequeue while empty is impossible because the mux gates on count.
- Starvation counter, width `BSG_SAFE_CLOG2(starve_limit_p+1)`:
  - Increments, saturating at starve_limit_p, on each cycle where count != 0 and inst_w_v_i=1.
  - Clears on any dequeue, or when count == 0.
  - Holds otherwise.
- stall_o = (starve_cnt_r == starve_limit_p). The microcode engine must drive inst_w_v_i=0 while stall_o=1.
  - If inst_w_v_i=1 anyway, the microcode write still wins and nothing is lost, but the condition is a protocol violation flagged by the bench.
- Dropping a microcode write is never permitted.
- Stale reads are tolerated: queued decrements are not yet visible in the store, so pending reads are conservatively high.
- Reset mid-operation: all FIFO contents are discarded, pointers, count and counter go to 0, and no write is issued in the reset cycle.

## Timing
- Reset values: mem_w_ready_o=1, w_v_o=0, pending_o=0, w_way_group_o=0, stall_o=0, empty_o=1.
- Combinational paths:
  - inst_* → w_* (microcode path latency 0).
  - count_r → mem_w_ready_o.
  - count_r / starve_cnt_r → empty_o / stall_o.
  - No combinational path from mem_w_v_i to any output.
- Memory decrement latency: 1 cycle minimum (enqueue at t, issue at t+1 if the microcode port is idle). Worst case: starve_limit_p + 1 additional cycles per entry under continuous microcode traffic, given a compliant engine.
- Once stall_o asserts, the following idle cycle dequeues, and stall_o deasserts in the next cycle.

## Test plan
- **Reset.** Assert reset_i for 2 cycles with mem_w_v_i=1 and inst_w_v_i=1 → w_v_o=0, mem_w_ready_o=1, empty_o=1 throughout reset. The first post-reset cycle shows the microcode write only.
- **Priority.** FIFO holds way group 3. Drive inst_w_v_i=1, way group 5, increment → w_way_group_o=5, pending_o=1, FIFO count stays 1. Next idle cycle → w_way_group_o=3, pending_o=0.
- **Fill and wrap** (els_p=4). Enqueue way groups 0, 1, 2, 3 while the microcode port is busy → mem_w_ready_o=0 after the 4th enqueue. Release the port, then enqueue 4, 5 during draining → issue order 0, 1, 2, 3, 4, 5 with pointer wrap, and empty_o=1 at the end.
- **Simultaneous enqueue/dequeue** at count=2 → count remains 2 and order is preserved.
- **Starvation** (starve_limit_p=8). FIFO holds 1 entry; hold inst_w_v_i=1 for 8 cycles → stall_o=1 on cycle 9. The engine idles → the entry issues that cycle, and stall_o=0 the next cycle.
- **Reset mid-drain.** 3 entries queued; pulse reset_i → none are issued afterward, and count=0.
